// File: rtl/pccm_ctrl_n_if.sv
// pccm_ctrl_n_if: NIOS PIO command/status plus CPU-array sync/halt/continue bundle.
interface pccm_ctrl_n_if #(
    parameter int NUM_CPU = 4
);
    logic [3:0]         pccm_ctl_con_export;
    logic [3:0]         pccm_rsp_con_export;
    logic [NUM_CPU-1:0] cpu_mask;
    logic [NUM_CPU-1:0] cpu_sync;
    logic [NUM_CPU-1:0] cpu_halt;
    logic [NUM_CPU-1:0] cpu_continue;
    logic               int_reset;
    logic               int_init;
    logic [15:0]        barrier_cnt;

    modport master (
        output pccm_ctl_con_export, cpu_mask, cpu_sync, cpu_halt,
        input  pccm_rsp_con_export, int_reset, int_init, cpu_continue, barrier_cnt
    );

    modport slave (
        input  pccm_ctl_con_export, cpu_mask, cpu_sync, cpu_halt,
        output pccm_rsp_con_export, int_reset, int_init, cpu_continue, barrier_cnt
    );
endinterface

// File: rtl/pccm_ctrl_n.sv
// pccm_ctrl_n: multi-core PCCM controller with timed init/reset, barrier release, halt detection and watchdog.
module pccm_ctrl_n #(
    parameter int NUM_CPU      = 4,
    parameter int INIT_CYCLES  = 256,
    parameter int RESET_CYCLES = 4,
    parameter int WDOG_CYCLES  = 65535
) (
    input logic          clk,
    input logic          reset,
    pccm_ctrl_n_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, START, RUNNING, DONE, ERROR, RESETTING, RESETED} state_t;

    localparam logic [3:0] CMD_ABORT  = 4'd1;
    localparam logic [3:0] CMD_GO     = 4'd2;
    localparam logic [3:0] CMD_RESET  = 4'd5;
    localparam logic [3:0] CMD_CLRERR = 4'd6;

    function automatic logic [3:0] rsp_of(input state_t s);
        return s == IDLE ? 4'd1 : s == DONE ? 4'd3 : s == ERROR ? 4'd4 : s == RESETED ? 4'd5 : 4'd2;
    endfunction

    state_t             state;
    logic [NUM_CPU-1:0] mask_q;
    logic [NUM_CPU-1:0] halt_q;
    logic               sync_all_q;
    logic [31:0]        cnt;
    logic [31:0]        wd;
    logic [3:0]         cmd;
    logic               sync_all;
    logic               halt_all;
    logic               sync_rise;
    logic               wd_clr;
    logic               wd_hit;

    assign cmd       = bus.pccm_ctl_con_export;
    assign sync_all  = &(bus.cpu_sync | ~mask_q);
    assign halt_all  = &(bus.cpu_halt | ~mask_q);
    assign sync_rise = sync_all & ~sync_all_q;
    assign wd_clr    = cmd == CMD_GO || sync_rise || bus.cpu_halt != halt_q;
    // Watchdog fires on the WDOG_CYCLES-th consecutive idle RUNNING cycle; 0 disables it.
    assign wd_hit    = WDOG_CYCLES != 0 && !wd_clr && wd == 32'(WDOG_CYCLES - 1);

    always_ff @(posedge clk) halt_q <= bus.cpu_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            bus.pccm_rsp_con_export <= 4'd1;
            bus.int_reset           <= 1'b0;
            bus.int_init            <= 1'b0;
            bus.cpu_continue        <= '0;
            bus.barrier_cnt         <= '0;
            mask_q                  <= '0;
            sync_all_q              <= 1'b0;
            cnt                     <= '0;
            wd                      <= '0;
        end else begin
            bus.cpu_continue <= '0;
            wd               <= wd_clr ? '0 : wd + 32'(state == RUNNING);
            case (state)
                IDLE: if (cmd == CMD_GO) begin
                    state                   <= INIT;
                    bus.pccm_rsp_con_export <= rsp_of(INIT);
                    bus.int_init            <= 1'b1;
                    bus.barrier_cnt         <= '0;
                    mask_q                  <= bus.cpu_mask;
                    cnt                     <= '0;
                end
                INIT: if (cnt == 32'(INIT_CYCLES - 1)) begin
                    state                   <= START;
                    bus.pccm_rsp_con_export <= rsp_of(START);
                    bus.int_init            <= 1'b0;
                    bus.cpu_continue        <= mask_q;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                START: begin
                    sync_all_q              <= sync_all;
                    state                   <= RUNNING;
                    bus.pccm_rsp_con_export <= rsp_of(RUNNING);
                end
                RUNNING: begin
                    sync_all_q <= sync_all;
                    // Halt outranks a same-cycle barrier: no release pulse, no count.
                    if (halt_all) begin
                        state                   <= DONE;
                        bus.pccm_rsp_con_export <= rsp_of(DONE);
                    end else if (sync_rise) begin
                        bus.cpu_continue <= mask_q;
                        bus.barrier_cnt  <= bus.barrier_cnt + 16'(bus.barrier_cnt != 16'hFFFF);
                    end else if (wd_hit) begin
                        state                   <= ERROR;
                        bus.pccm_rsp_con_export <= rsp_of(ERROR);
                    end
                end
                ERROR: if (cmd == CMD_CLRERR) begin
                    state                   <= IDLE;
                    bus.pccm_rsp_con_export <= rsp_of(IDLE);
                end
                RESETTING: if (cnt == 32'(RESET_CYCLES - 1)) begin
                    state                   <= RESETED;
                    bus.pccm_rsp_con_export <= rsp_of(RESETED);
                    bus.int_reset           <= 1'b0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                default: ;
            endcase
            if (cmd == CMD_RESET) begin
                state                   <= RESETTING;
                bus.pccm_rsp_con_export <= rsp_of(RESETTING);
                bus.int_reset           <= 1'b1;
                bus.int_init            <= 1'b0;
                bus.cpu_continue        <= '0;
                cnt                     <= '0;
            end else if (cmd == CMD_ABORT) begin
                state                   <= IDLE;
                bus.pccm_rsp_con_export <= rsp_of(IDLE);
                bus.int_reset           <= 1'b0;
                bus.int_init            <= 1'b0;
                bus.cpu_continue        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pccm_ctrl_n.sv
// tb_pccm_ctrl_n: directed and randomized stimulus against a phase/countdown model of the controller.
module tb_pccm_ctrl_n;
    localparam int N      = 4;
    localparam int INIT_C = 256;
    localparam int RST_C  = 4;
    localparam int WD_C   = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pccm_ctrl_n_if #(.NUM_CPU(N)) bus ();

    pccm_ctrl_n #(
        .NUM_CPU(N), .INIT_CYCLES(INIT_C), .RESET_CYCLES(RST_C), .WDOG_CYCLES(WD_C)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef enum {P_IDLE, P_INIT, P_START, P_RUN, P_DONE, P_ERR, P_RST, P_RSTD} phase_t;

    phase_t       ph;
    int           left;
    int           idle;
    logic [N-1:0] m_mask;
    logic [N-1:0] m_halt_q;
    logic         m_sa_q;
    logic [N-1:0] e_cont;
    logic [15:0]  e_bcnt;
    logic [3:0]   e_rsp;
    logic         e_init;
    logic         e_reset;
    int           n_chk = 0;
    int           n_fail = 0;
    bit           chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock edge of the reference: phases with countdown timers, outputs derived from the phase.
    task automatic model_step();
        logic [3:0] c;
        logic       sa, ha, rise, hchg;
        c    = bus.pccm_ctl_con_export;
        sa   = &(bus.cpu_sync | ~m_mask);
        ha   = &(bus.cpu_halt | ~m_mask);
        rise = sa && !m_sa_q;
        hchg = bus.cpu_halt != m_halt_q;
        m_halt_q = bus.cpu_halt;
        e_cont = '0;
        if (reset) begin
            ph = P_IDLE; m_mask = '0; e_bcnt = '0; m_sa_q = 1'b0; idle = 0; left = 0;
        end else begin
            if (c == 4'd2 || (ph == P_RUN && (rise || hchg))) idle = 0;
            else if (ph == P_RUN) idle++;
            case (ph)
                P_IDLE: if (c == 4'd2) begin
                    ph = P_INIT; m_mask = bus.cpu_mask; e_bcnt = '0; left = INIT_C;
                end
                P_INIT: begin
                    left--;
                    if (left == 0) begin ph = P_START; e_cont = m_mask; end
                end
                P_START: begin m_sa_q = sa; ph = P_RUN; end
                P_RUN: begin
                    m_sa_q = sa;
                    if (ha) ph = P_DONE;
                    else if (rise) begin
                        e_cont = m_mask;
                        if (e_bcnt != 16'hFFFF) e_bcnt++;
                    end else if (idle == WD_C) ph = P_ERR;
                end
                P_ERR: if (c == 4'd6) ph = P_IDLE;
                P_RST: begin
                    left--;
                    if (left == 0) ph = P_RSTD;
                end
                default: ;
            endcase
            if (c == 4'd5) begin ph = P_RST; left = RST_C; e_cont = '0; end
            else if (c == 4'd1) begin ph = P_IDLE; e_cont = '0; end
        end
        e_init  = ph == P_INIT;
        e_reset = ph == P_RST;
        e_rsp   = ph == P_IDLE ? 4'd1 : ph == P_DONE ? 4'd3 : ph == P_ERR ? 4'd4 : ph == P_RSTD ? 4'd5 : 4'd2;
    endtask

    task automatic tick(input logic [3:0] c, input logic [N-1:0] m, input logic [N-1:0] s, input logic [N-1:0] h);
        bus.pccm_ctl_con_export = c;
        bus.cpu_mask = m;
        bus.cpu_sync = s;
        bus.cpu_halt = h;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) if (chk_en) begin
        cmp("rsp", 32'(bus.pccm_rsp_con_export), 32'(e_rsp));
        cmp("int_init", 32'(bus.int_init), 32'(e_init));
        cmp("int_reset", 32'(bus.int_reset), 32'(e_reset));
        cmp("cpu_continue", 32'(bus.cpu_continue), 32'(e_cont));
        cmp("barrier_cnt", 32'(bus.barrier_cnt), 32'(e_bcnt));
    end

    initial begin
        int n;
        int r;
        logic [3:0]   c;
        logic [N-1:0] m, s, h;
        tick(4'd0, 4'h0, 4'h0, 4'h0);
        chk_en = 1'b1;
        tick(4'd0, 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        tick(4'd0, 4'h0, 4'h0, 4'h0);
        cmp("reset_rsp", 32'(bus.pccm_rsp_con_export), 32'd1);
        cmp("reset_outs", 32'({bus.int_init, bus.int_reset, bus.cpu_continue, bus.barrier_cnt}), 32'd0);

        tick(4'd2, 4'hF, 4'h0, 4'h0);
        n = 0;
        while (bus.int_init && n < 400) begin n++; tick(4'd0, 4'hF, 4'h0, 4'h0); end
        cmp("init_len", 32'(n), 32'd256);
        cmp("start_cont", 32'(bus.cpu_continue), 32'hF);
        cmp("start_rsp", 32'(bus.pccm_rsp_con_export), 32'd2);
        tick(4'd0, 4'hF, 4'h0, 4'h0);
        cmp("run_cont_clear", 32'(bus.cpu_continue), 32'd0);

        n = 0;
        repeat (10) begin tick(4'd0, 4'hF, 4'hF, 4'h0); if (bus.cpu_continue != 0) n++; end
        cmp("one_pulse", 32'(n), 32'd1);
        cmp("bcnt_1", 32'(bus.barrier_cnt), 32'd1);
        tick(4'd0, 4'hF, 4'h0, 4'h0);
        tick(4'd0, 4'hF, 4'h0, 4'h0);
        n = 0;
        repeat (3) begin tick(4'd0, 4'hF, 4'hF, 4'h0); if (bus.cpu_continue != 0) n++; end
        cmp("second_pulse", 32'(n), 32'd1);
        cmp("bcnt_2", 32'(bus.barrier_cnt), 32'd2);
        tick(4'd0, 4'hF, 4'h0, 4'h0);
        tick(4'd0, 4'hF, 4'hF, 4'hF);
        cmp("halt_wins_cont", 32'(bus.cpu_continue), 32'd0);
        cmp("halt_wins_rsp", 32'(bus.pccm_rsp_con_export), 32'd3);
        cmp("halt_wins_bcnt", 32'(bus.barrier_cnt), 32'd2);
        tick(4'd1, 4'hF, 4'h0, 4'h0);
        cmp("abort_rsp", 32'(bus.pccm_rsp_con_export), 32'd1);

        tick(4'd2, 4'b0101, 4'h0, 4'h0);
        n = 0;
        while (bus.int_init && n < 400) begin n++; tick(4'd0, 4'b0101, 4'h0, 4'h0); end
        cmp("mask_start_cont", 32'(bus.cpu_continue), 32'h5);
        tick(4'd0, 4'b0101, 4'h0, 4'h0);
        tick(4'd0, 4'b0101, 4'b0101, 4'h0);
        cmp("mask_pulse", 32'(bus.cpu_continue), 32'h5);
        tick(4'd0, 4'b0101, 4'b0101, 4'b0101);
        cmp("mask_done", 32'(bus.pccm_rsp_con_export), 32'd3);
        tick(4'd1, 4'hF, 4'h0, 4'h0);

        tick(4'd2, 4'hF, 4'h0, 4'h0);
        n = 0;
        while (bus.int_init && n < 400) begin n++; tick(4'd0, 4'hF, 4'h0, 4'h0); end
        tick(4'd0, 4'hF, 4'h0, 4'h0);
        n = 0;
        while (bus.pccm_rsp_con_export != 4'd4 && n < 300) begin n++; tick(4'd0, 4'hF, 4'h0, 4'h0); end
        cmp("wdog_cycles", 32'(n), 32'd100);
        tick(4'd6, 4'hF, 4'h0, 4'h0);
        cmp("clrerr_rsp", 32'(bus.pccm_rsp_con_export), 32'd1);

        tick(4'd2, 4'hF, 4'h0, 4'h0);
        repeat (10) tick(4'd0, 4'hF, 4'h0, 4'h0);
        tick(4'd5, 4'hF, 4'h0, 4'h0);
        cmp("rst_init_low", 32'(bus.int_init), 32'd0);
        n = 0;
        while (bus.int_reset && n < 20) begin n++; tick(4'd0, 4'hF, 4'h0, 4'h0); end
        cmp("rst_len", 32'(n), 32'd4);
        cmp("reseted_rsp", 32'(bus.pccm_rsp_con_export), 32'd5);
        tick(4'd1, 4'hF, 4'h0, 4'h0);
        cmp("abort_reseted_rsp", 32'(bus.pccm_rsp_con_export), 32'd1);

        tick(4'd2, 4'h0, 4'h0, 4'h0);
        n = 0;
        while (bus.int_init && n < 400) begin n++; tick(4'd0, 4'h0, 4'h0, 4'h0); end
        cmp("zero_mask_cont", 32'(bus.cpu_continue), 32'd0);
        tick(4'd0, 4'h0, 4'h0, 4'h0);
        tick(4'd0, 4'h0, 4'h0, 4'h0);
        cmp("zero_mask_done", 32'(bus.pccm_rsp_con_export), 32'd3);
        tick(4'd1, 4'h0, 4'h0, 4'h0);

        s = '0;
        h = '0;
        for (int i = 0; i < 30000; i++) begin
            r = int'($urandom_range(0, 999));
            c = r < 30 ? 4'd2 : r < 33 ? 4'd1 : r < 35 ? 4'd5 : r < 45 ? 4'd6 : r < 55 ? 4'($urandom_range(0, 15)) : 4'd0;
            m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            if ($urandom_range(0, 9) == 0) s = N'($urandom);
            if ($urandom_range(0, 49) == 0) h = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom);
            reset = $urandom_range(0, 2999) == 0;
            tick(c, m, s, h);
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
